// File: rtl/barrel_pkg.sv
// Shared constants for the barrel sprite slots and the slot scheduler.
package barrel_pkg;

    localparam int unsigned BARREL_NUM_MAX = 16;

    typedef logic [1:0] barrel_state_t;
    localparam barrel_state_t BARREL_INITIAL = 2'd0;
    localparam barrel_state_t BARREL_ROLLING = 2'd1;
    localparam barrel_state_t BARREL_FALLING = 2'd2;

    typedef logic [1:0] sch_state_t;
    localparam sch_state_t SCH_IDLE     = 2'd0;
    localparam sch_state_t SCH_GRANT    = 2'd1;
    localparam sch_state_t SCH_COOLDOWN = 2'd2;

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin first-free search: lowest free index at or above ptr, wrapping.
module rr_free_picker
    import barrel_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = BARREL_NUM_MAX,
    parameter int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] free,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    always_comb begin
        int unsigned j;
        logic [IDX_W-1:0] jj;
        found = 1'b0;
        index = '0;
        j     = 0;
        jj    = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            j  = (32'(ptr) + k) % NUM_SLOTS;
            jj = IDX_W'(j);
            if (!found && free[jj]) begin
                found = 1'b1;
                index = jj;
            end
        end
    end

endmodule

// File: rtl/barrel_scheduler.sv
// Turns Kong drop edges into held one-hot start requests to free barrel slots
// and tracks which slots are occupied.
module barrel_scheduler
    import barrel_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = BARREL_NUM_MAX,
    parameter int unsigned COOLDOWN_CYCLES = 1000000,
    parameter int unsigned ACK_TIMEOUT     = 2000000,
    parameter int unsigned PEND_MAX        = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           drop_req,
    input  logic [NUM_SLOTS-1:0]           slot_busy,
    output logic [NUM_SLOTS-1:0]           start_vec,
    output logic [NUM_SLOTS-1:0]           active_vec,
    output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
    output logic [15:0]                    spawn_count,
    output logic [7:0]                     lost_count
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int unsigned PW    = $clog2(PEND_MAX + 1);
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    logic [NUM_SLOTS-1:0] busy_s1_q, busy_s2_q;
    logic                 drop_q;
    sch_state_t           state_q, state_d;
    logic [PW-1:0]        pend_q, pend_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [NUM_SLOTS-1:0] start_q, start_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [15:0]          spawn_q, spawn_d;
    logic [7:0]           lost_q, lost_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [CD_W-1:0]      cd_q, cd_d;

    logic                 drop_edge;
    logic [NUM_SLOTS-1:0] free_mask;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 go, ack, tmo, ovf;
    logic [1:0]           lost_inc;
    logic [IDX_W-1:0]     gidx_next;

    assign drop_edge = drop_req & ~drop_q;
    assign free_mask = ~active_q & ~busy_s2_q;

    rr_free_picker #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .free  (free_mask),
        .ptr   (rr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    // Every event that moves counters is qualified by enable so they hold while disabled.
    assign go  = enable && (state_q == SCH_IDLE) && (pend_q != '0) && pick_found;
    assign ack = enable && (state_q == SCH_GRANT) && busy_s2_q[gidx_q];
    assign tmo = enable && (state_q == SCH_GRANT) && !busy_s2_q[gidx_q]
                 && (timer_q == TMR_W'(ACK_TIMEOUT - 1));
    assign ovf = enable && drop_edge && (pend_q == PW'(PEND_MAX)) && !go;

    assign gidx_next = (gidx_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : gidx_q + 1'b1;
    assign lost_inc  = {1'b0, ovf} + {1'b0, tmo};

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        start_d  = start_q;
        active_d = active_q & busy_s2_q;
        spawn_d  = spawn_q;
        lost_d   = lost_q;
        timer_d  = timer_q;
        cd_d     = cd_q;

        unique case (state_q)
            SCH_IDLE: begin
                if (go) begin
                    state_d           = SCH_GRANT;
                    gidx_d            = pick_idx;
                    start_d           = '0;
                    start_d[pick_idx] = 1'b1;
                    timer_d           = '0;
                end
            end
            SCH_GRANT: begin
                timer_d = timer_q + 1'b1;
                if (ack || tmo) begin
                    state_d = SCH_COOLDOWN;
                    start_d = '0;
                    rr_d    = gidx_next;
                    cd_d    = CD_W'(COOLDOWN_CYCLES - 1);
                end
                if (ack) begin
                    active_d[gidx_q] = 1'b1;
                    spawn_d          = spawn_q + 16'd1;
                end
            end
            SCH_COOLDOWN: begin
                if (cd_q == '0) begin
                    state_d = SCH_IDLE;
                end else begin
                    cd_d = cd_q - 1'b1;
                end
            end
            default: begin
                state_d = SCH_IDLE;
                start_d = '0;
            end
        endcase

        if (drop_edge && !go && pend_q != PW'(PEND_MAX)) begin
            pend_d = pend_q + 1'b1;
        end else if (go && !drop_edge) begin
            pend_d = pend_q - 1'b1;
        end

        if (lost_inc != 2'd0) begin
            lost_d = (lost_q > 8'd255 - {6'd0, lost_inc}) ? 8'd255 : lost_q + {6'd0, lost_inc};
        end

        if (!enable) begin
            state_d = SCH_IDLE;
            start_d = '0;
            pend_d  = '0;
            cd_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_s1_q <= '0;
            busy_s2_q <= '0;
            drop_q    <= 1'b0;
            state_q   <= SCH_IDLE;
            pend_q    <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            start_q   <= '0;
            active_q  <= '0;
            spawn_q   <= '0;
            lost_q    <= '0;
            timer_q   <= '0;
            cd_q      <= '0;
        end else begin
            busy_s1_q <= slot_busy;
            busy_s2_q <= busy_s1_q;
            drop_q    <= drop_req;
            state_q   <= state_d;
            pend_q    <= pend_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            start_q   <= start_d;
            active_q  <= active_d;
            spawn_q   <= spawn_d;
            lost_q    <= lost_d;
            timer_q   <= timer_d;
            cd_q      <= cd_d;
        end
    end

    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = CNT_W'(NUM_SLOTS);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt - CNT_W'(active_q[i]);
        end
        free_count = cnt;
    end

    assign start_vec   = start_q;
    assign active_vec  = active_q;
    assign spawn_count = spawn_q;
    assign lost_count  = lost_q;

endmodule

// File: tb/tb_barrel_scheduler.sv
// Directed bench for barrel_scheduler with a 4-slot barrel model that acks 3 cycles after start.
module tb_barrel_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        drop_req;
    logic [3:0]  slot_busy;
    logic [3:0]  start_vec;
    logic [3:0]  active_vec;
    logic [2:0]  free_count;
    logic [15:0] spawn_count;
    logic [7:0]  lost_count;

    logic [3:0]  busy_m;
    logic [3:0]  hold;
    logic        ack_en;
    logic [1:0]  dly [4];

    int checks = 0;
    int errors = 0;
    int n;

    barrel_scheduler #(
        .NUM_SLOTS       (4),
        .COOLDOWN_CYCLES (4),
        .ACK_TIMEOUT     (8),
        .PEND_MAX        (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .drop_req    (drop_req),
        .slot_busy   (slot_busy),
        .start_vec   (start_vec),
        .active_vec  (active_vec),
        .free_count  (free_count),
        .spawn_count (spawn_count),
        .lost_count  (lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign slot_busy = busy_m | hold;

    // Barrel model: busy rises on the third clock edge that sees its start request.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                busy_m[i] <= 1'b0;
                dly[i]    <= 2'd0;
            end else if (start_vec[i] && ack_en) begin
                if (dly[i] == 2'd2) busy_m[i] <= 1'b1;
                else                dly[i]    <= dly[i] + 2'd1;
            end else begin
                dly[i] <= 2'd0;
            end
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        drop_req = 1'b1;
        tick(1);
        drop_req = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        drop_req = 1'b0;
        hold     = 4'h0;
        ack_en   = 1'b1;
        tick(2);
        rst    = 1'b0;
        enable = 1'b1;
        tick(3);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        drop_req = 1'b0;
        hold     = 4'h0;
        ack_en   = 1'b1;
        tick(2);
        chk("rst_start", 32'(start_vec), 32'h0);
        chk("rst_active", 32'(active_vec), 32'h0);
        chk("rst_free", 32'(free_count), 32'd4);
        chk("rst_spawn", 32'(spawn_count), 32'd0);
        chk("rst_lost", 32'(lost_count), 32'd0);

        // 1: single drop, grant at t+2, ack lands at t+8
        do_reset();
        drop_req = 1'b1;
        tick(1);
        chk("t1_start_t1", 32'(start_vec), 32'h0);
        drop_req = 1'b0;
        tick(1);
        chk("t1_start_t2", 32'(start_vec), 32'h1);
        tick(5);
        chk("t1_start_held", 32'(start_vec), 32'h1);
        tick(1);
        chk("t1_start_drop", 32'(start_vec), 32'h0);
        chk("t1_active", 32'(active_vec), 32'h1);
        chk("t1_spawn", 32'(spawn_count), 32'd1);
        chk("t1_free", 32'(free_count), 32'd3);

        // 2: four edges with all slots blocked saturate pend, then drain to 0,1,2
        do_reset();
        hold = 4'hF;
        tick(3);
        for (int k = 0; k < 4; k++) pulse();
        chk("t2_lost", 32'(lost_count), 32'd1);
        chk("t2_no_start", 32'(start_vec), 32'h0);
        hold = 4'h0;
        tick(3);
        chk("t2_grant0", 32'(start_vec), 32'h1);
        tick(10);
        chk("t2_gap", 32'(start_vec), 32'h0);
        tick(1);
        chk("t2_grant1", 32'(start_vec), 32'h2);
        tick(11);
        chk("t2_grant2", 32'(start_vec), 32'h4);
        tick(6);
        chk("t2_spawn", 32'(spawn_count), 32'd3);
        chk("t2_active", 32'(active_vec), 32'h7);
        chk("t2_free", 32'(free_count), 32'd1);
        chk("t2_lost_end", 32'(lost_count), 32'd1);
        tick(12);
        chk("t2_drained", 32'(start_vec), 32'h0);

        // 3: all busy, then release slot 2
        do_reset();
        hold = 4'hF;
        tick(3);
        pulse();
        tick(5);
        chk("t3_blocked", 32'(start_vec), 32'h0);
        hold = 4'b1011;
        tick(2);
        chk("t3_pre_grant", 32'(start_vec), 32'h0);
        tick(1);
        chk("t3_grant", 32'(start_vec), 32'h4);
        tick(6);
        chk("t3_active", 32'(active_vec), 32'h4);
        chk("t3_spawn", 32'(spawn_count), 32'd1);

        // 4: no acknowledge, start held exactly ACK_TIMEOUT cycles
        do_reset();
        ack_en = 1'b0;
        pulse();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (start_vec != 4'h0) n++;
            tick(1);
        end
        chk("t4_held_cycles", 32'(n), 32'd8);
        chk("t4_lost", 32'(lost_count), 32'd1);
        chk("t4_spawn", 32'(spawn_count), 32'd0);
        ack_en = 1'b1;
        pulse();
        chk("t4_next_index", 32'(start_vec), 32'h2);

        // 5: enable drop during GRANT clears start and pend
        do_reset();
        ack_en = 1'b0;
        pulse();
        chk("t5_grant", 32'(start_vec), 32'h1);
        pulse();
        enable = 1'b0;
        tick(1);
        chk("t5_start_off", 32'(start_vec), 32'h0);
        tick(2);
        enable = 1'b1;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (start_vec != 4'h0) n++;
            tick(1);
        end
        chk("t5_no_regrant", 32'(n), 32'd0);
        chk("t5_lost", 32'(lost_count), 32'd0);
        pulse();
        chk("t5_new_grant", 32'(start_vec), 32'h1);

        // 6: reset during GRANT with two pending requests
        do_reset();
        pulse();
        tick(10);
        chk("t6_spawn_pre", 32'(spawn_count), 32'd1);
        ack_en = 1'b0;
        pulse();
        chk("t6_grant1", 32'(start_vec), 32'h2);
        pulse();
        pulse();
        chk("t6_still_grant", 32'(start_vec), 32'h2);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_start", 32'(start_vec), 32'h0);
        chk("t6_rst_active", 32'(active_vec), 32'h0);
        chk("t6_rst_free", 32'(free_count), 32'd4);
        chk("t6_rst_spawn", 32'(spawn_count), 32'd0);
        chk("t6_rst_lost", 32'(lost_count), 32'd0);
        rst    = 1'b0;
        ack_en = 1'b1;
        tick(3);
        chk("t6_no_pend", 32'(start_vec), 32'h0);
        pulse();
        chk("t6_rr_restart", 32'(start_vec), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
